// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection, flush/halt bubble
// insertion, a sticky halt flag and a saturating load-use bubble counter.
//
// Control-word bit positions (EXStage / MAStage / WBStage layouts):
//   ex_ctrl[14] NEED_RS1, ex_ctrl[13] NEED_RS2
//   ma_ctrl[1]  MA_EN,    ma_ctrl[0]  MA_RW (1 = write/store, 0 = read/load)
//   wb_ctrl[2]  WB_R_WE   (register-file write enable)
module id_ex_register #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [14:0]       id_ex_ctrl,
  input  logic [1:0]        id_ma_ctrl,
  input  logic [2:0]        id_wb_ctrl,
  input  logic              id_hlt,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_val,
  input  logic [DATA_W-1:0] id_rs2_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  output logic              ex_valid,
  output logic [14:0]       ex_ex_ctrl,
  output logic [1:0]        ex_ma_ctrl,
  output logic [2:0]        ex_wb_ctrl,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rs1_val,
  output logic [DATA_W-1:0] ex_rs2_val,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs1_addr,
  output logic [REG_AW-1:0] ex_rs2_addr,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              load_use_stall,
  output logic              halted,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int EX_NEED_RS1 = 14;
  localparam int EX_NEED_RS2 = 13;
  localparam int MA_EN       = 1;
  localparam int MA_RW       = 0;
  localparam int WB_R_WE     = 2;

  typedef struct packed {
    logic              valid;
    logic [14:0]       ex_ctrl;
    logic [1:0]        ma_ctrl;
    logic [2:0]        wb_ctrl;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
  } ex_stage_t;

  ex_stage_t            stage_d, stage_q;
  logic                 halted_d, halted_q;
  logic [CNT_W-1:0]     bubble_cnt_d, bubble_cnt_q;
  logic                 ex_is_load;
  logic                 id_depends;

  // Hazard: EX holds a register-writing load whose rd is a source decode needs.
  always_comb begin
    ex_is_load     = stage_q.valid && stage_q.ma_ctrl[MA_EN] &&
                     !stage_q.ma_ctrl[MA_RW] && stage_q.wb_ctrl[WB_R_WE];
    id_depends     = (id_ex_ctrl[EX_NEED_RS1] && (id_rs1_addr == stage_q.rd_addr)) ||
                     (id_ex_ctrl[EX_NEED_RS2] && (id_rs2_addr == stage_q.rd_addr));
    load_use_stall = ex_is_load && id_valid && id_depends && !flush && !halted_q;
  end

  // Next-state selection: stall holds, flush/halt/load-use bubble, else capture.
  always_comb begin
    // NOTE: every variable gets a hold default first so no path infers a latch.
    stage_d      = stage_q;
    halted_d     = halted_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall) begin
      // hold everything
    end else if (flush || halted_q || load_use_stall) begin
      // Bubble: kill the slot and its side effects, leave datapath fields as-is.
      stage_d.valid   = 1'b0;
      stage_d.ex_ctrl = '0;
      stage_d.ma_ctrl = '0;
      stage_d.wb_ctrl = '0;
      if (load_use_stall && (bubble_cnt_q != {CNT_W{1'b1}})) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else begin
      stage_d.valid    = id_valid;
      stage_d.ex_ctrl  = id_valid ? id_ex_ctrl : '0;
      stage_d.ma_ctrl  = id_valid ? id_ma_ctrl : '0;
      stage_d.wb_ctrl  = id_valid ? id_wb_ctrl : '0;
      stage_d.pc       = id_pc;
      stage_d.rs1_val  = id_rs1_val;
      stage_d.rs2_val  = id_rs2_val;
      stage_d.imm      = id_imm;
      stage_d.rs1_addr = id_rs1_addr;
      stage_d.rs2_addr = id_rs2_addr;
      stage_d.rd_addr  = id_rd_addr;
      // The HLT itself still enters EX; halting takes effect from the next slot.
      halted_d         = id_valid && id_hlt;
    end
  end

  // State registers with synchronous reset overriding stall.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      stage_q      <= '0;
      halted_q     <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      halted_q     <= halted_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid    = stage_q.valid;
  assign ex_ex_ctrl  = stage_q.ex_ctrl;
  assign ex_ma_ctrl  = stage_q.ma_ctrl;
  assign ex_wb_ctrl  = stage_q.wb_ctrl;
  assign ex_pc       = stage_q.pc;
  assign ex_rs1_val  = stage_q.rs1_val;
  assign ex_rs2_val  = stage_q.rs2_val;
  assign ex_imm      = stage_q.imm;
  assign ex_rs1_addr = stage_q.rs1_addr;
  assign ex_rs2_addr = stage_q.rs2_addr;
  assign ex_rd_addr  = stage_q.rd_addr;
  assign halted      = halted_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: directed vector table, multi-cycle sequences and
// randomized traffic, all compared against a rule-level reference model.
// A second instance with CNT_W=2 exercises counter saturation.
module tb_id_ex_register;

  localparam int NEED1 = 14, NEED2 = 13, MA_EN = 1, MA_RW = 0, WB_WE = 2;

  logic        clk;
  logic        rst, stall, flush, id_valid, id_hlt;
  logic [14:0] id_ex_ctrl;
  logic [1:0]  id_ma_ctrl;
  logic [2:0]  id_wb_ctrl;
  logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;

  logic        ex_valid, load_use_stall, halted;
  logic [14:0] ex_ex_ctrl;
  logic [1:0]  ex_ma_ctrl;
  logic [2:0]  ex_wb_ctrl;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [15:0] bubble_cnt;

  logic        s_valid, s_lus, s_halted;
  logic [14:0] s_exc;
  logic [1:0]  s_mac;
  logic [2:0]  s_wbc;
  logic [31:0] s_pc, s_r1, s_r2, s_imm;
  logic [4:0]  s_a1, s_a2, s_rd;
  logic [1:0]  s_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_register dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_ex_ctrl(id_ex_ctrl), .id_ma_ctrl(id_ma_ctrl), .id_wb_ctrl(id_wb_ctrl),
    .id_hlt(id_hlt), .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .ex_valid(ex_valid), .ex_ex_ctrl(ex_ex_ctrl),
    .ex_ma_ctrl(ex_ma_ctrl), .ex_wb_ctrl(ex_wb_ctrl), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .load_use_stall(load_use_stall), .halted(halted), .bubble_cnt(bubble_cnt)
  );

  id_ex_register #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_ex_ctrl(id_ex_ctrl), .id_ma_ctrl(id_ma_ctrl), .id_wb_ctrl(id_wb_ctrl),
    .id_hlt(id_hlt), .id_pc(id_pc), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
    .id_imm(id_imm), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr), .ex_valid(s_valid), .ex_ex_ctrl(s_exc),
    .ex_ma_ctrl(s_mac), .ex_wb_ctrl(s_wbc), .ex_pc(s_pc),
    .ex_rs1_val(s_r1), .ex_rs2_val(s_r2), .ex_imm(s_imm),
    .ex_rs1_addr(s_a1), .ex_rs2_addr(s_a2), .ex_rd_addr(s_rd),
    .load_use_stall(s_lus), .halted(s_halted), .bubble_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what EX should hold, plus an unbounded bubble tally.
  typedef struct packed {
    logic        valid;
    logic [14:0] exc;
    logic [1:0]  mac;
    logic [2:0]  wbc;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  a1, a2, rd;
    logic        halted;
    int          cnt;
  } model_t;

  model_t m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int max);
    return (c > max) ? max : c;
  endfunction

  // Stall rule: EX is a register-writing load that decode's needed source reads.
  function automatic logic model_lus();
    logic ex_load, dep;
    ex_load = m.valid && m.mac[MA_EN] && !m.mac[MA_RW] && m.wbc[WB_WE];
    dep = (id_ex_ctrl[NEED1] && id_rs1_addr == m.rd) ||
          (id_ex_ctrl[NEED2] && id_rs2_addr == m.rd);
    return ex_load && id_valid && dep && !flush && !m.halted;
  endfunction

  function automatic model_t model_next();
    model_t n;
    n = m;
    if (rst) begin
      n = '0;
    end else if (stall) begin
      n = m;
    end else if (flush || m.halted || model_lus()) begin
      n.valid = 1'b0;
      n.exc = '0; n.mac = '0; n.wbc = '0;
      if (model_lus()) n.cnt = m.cnt + 1;
    end else begin
      n.valid = id_valid;
      n.exc = id_valid ? id_ex_ctrl : 15'h0;
      n.mac = id_valid ? id_ma_ctrl : 2'h0;
      n.wbc = id_valid ? id_wb_ctrl : 3'h0;
      n.pc = id_pc; n.r1 = id_rs1_val; n.r2 = id_rs2_val; n.imm = id_imm;
      n.a1 = id_rs1_addr; n.a2 = id_rs2_addr; n.rd = id_rd_addr;
      n.halted = id_valid && id_hlt;
    end
    return n;
  endfunction

  task automatic compare_all();
    check("ex_valid",    ex_valid,    m.valid);
    check("ex_ex_ctrl",  ex_ex_ctrl,  m.exc);
    check("ex_ma_ctrl",  ex_ma_ctrl,  m.mac);
    check("ex_wb_ctrl",  ex_wb_ctrl,  m.wbc);
    check("ex_pc",       ex_pc,       m.pc);
    check("ex_rs1_val",  ex_rs1_val,  m.r1);
    check("ex_rs2_val",  ex_rs2_val,  m.r2);
    check("ex_imm",      ex_imm,      m.imm);
    check("ex_rs1_addr", ex_rs1_addr, m.a1);
    check("ex_rs2_addr", ex_rs2_addr, m.a2);
    check("ex_rd_addr",  ex_rd_addr,  m.rd);
    check("halted",      halted,      m.halted);
    check("bubble_cnt",  bubble_cnt,  sat(m.cnt, 65535));
    check("bubble_cnt_w2", s_cnt,     sat(m.cnt, 3));
  endtask

  // One clock: inputs already driven; check combinational stall, then state.
  task automatic tick();
    model_t nx;
    #1;
    check("load_use_stall", load_use_stall, model_lus());
    nx = model_next();
    @(posedge clk);
    #1;
    m = nx;
    compare_all();
  endtask

  task automatic set_id(input logic v, input logic [14:0] exc, input logic [1:0] mac,
                        input logic [2:0] wbc, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] rd, input logic [31:0] pc);
    id_valid = v; id_ex_ctrl = exc; id_ma_ctrl = mac; id_wb_ctrl = wbc;
    id_rs1_addr = a1; id_rs2_addr = a2; id_rd_addr = rd; id_pc = pc;
    id_hlt = 1'b0;
    id_rs1_val = $urandom; id_rs2_val = $urandom; id_imm = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        vld;
    logic [14:0] exc;
    logic [1:0]  mac;
    logic [2:0]  wbc;
    logic [4:0]  a1, a2, rd;
    logic        flush;
    logic [31:0] pc;
    logic        exp_lus;
    logic        exp_valid;
    int          exp_cnt;
  } vec_t;

  localparam logic [14:0] X_LD  = 15'h0000, X_ADD = 15'h4000, X_ST = 15'h2000;
  localparam logic [1:0]  M_LD  = 2'b10,    M_ST  = 2'b11,    M_NO = 2'b00;
  localparam logic [2:0]  W_WE  = 3'b100,   W_NO  = 3'b000;

  initial begin
    vec_t vecs[14];

    // Power-up: bring the DUT to a known state before the model tracks it.
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0);
    @(posedge clk);
    #1;
    m = '0;
    do_reset();

    // ---------------- directed vector table ----------------
    //          vld  exc    mac   wbc   a1 a2 rd fl  pc      lus valid cnt
    vecs[0]  = '{1, X_LD,  M_LD, W_WE, 1, 0, 3, 0, 32'h10, 0, 1, 0};
    vecs[1]  = '{1, X_ADD, M_NO, W_WE, 3, 2, 5, 0, 32'h14, 1, 0, 1};
    vecs[2]  = '{1, X_ADD, M_NO, W_WE, 3, 2, 5, 0, 32'h14, 0, 1, 1};
    vecs[3]  = '{1, X_LD,  M_LD, W_WE, 1, 0, 3, 0, 32'h18, 0, 1, 1};
    vecs[4]  = '{1, X_ST,  M_ST, W_NO, 3, 3, 0, 0, 32'h1c, 1, 0, 2};
    vecs[5]  = '{1, X_ST,  M_ST, W_NO, 3, 3, 0, 0, 32'h1c, 0, 1, 2};
    vecs[6]  = '{1, X_LD,  M_LD, W_WE, 1, 0, 3, 0, 32'h20, 0, 1, 2};
    vecs[7]  = '{1, X_ST,  M_ST, W_NO, 3, 4, 0, 0, 32'h24, 0, 1, 2};
    vecs[8]  = '{1, X_LD,  M_LD, W_WE, 1, 0, 3, 0, 32'h28, 0, 1, 2};
    vecs[9]  = '{1, X_ADD, M_NO, W_WE, 3, 2, 5, 1, 32'h2c, 0, 0, 2};
    vecs[10] = '{1, X_LD,  M_LD, W_WE, 1, 0, 7, 0, 32'h30, 0, 1, 2};
    vecs[11] = '{0, X_ADD, M_NO, W_WE, 7, 2, 5, 0, 32'h34, 0, 0, 2};
    vecs[12] = '{1, X_LD,  M_LD, W_NO, 1, 0, 7, 0, 32'h38, 0, 1, 2};
    vecs[13] = '{1, X_ADD, M_NO, W_WE, 7, 2, 5, 0, 32'h3c, 0, 1, 2};

    for (int i = 0; i < 14; i++) begin
      set_id(vecs[i].vld, vecs[i].exc, vecs[i].mac, vecs[i].wbc,
             vecs[i].a1, vecs[i].a2, vecs[i].rd, vecs[i].pc);
      flush = vecs[i].flush;
      #1;
      check($sformatf("vec%0d_lus", i), load_use_stall, vecs[i].exp_lus);
      tick();
      check($sformatf("vec%0d_valid", i), ex_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_cnt", i), bubble_cnt, vecs[i].exp_cnt);
      if (!vecs[i].exp_valid)
        check($sformatf("vec%0d_ctrl_zero", i), {ex_ex_ctrl, ex_ma_ctrl, ex_wb_ctrl}, 20'h0);
    end
    flush = 1'b0;

    // ---------------- stall holds a load in EX for 3 cycles ----------------
    do_reset();
    set_id(1'b1, X_LD, M_LD, W_WE, 1, 0, 3, 32'h40);
    tick();
    stall = 1'b1;
    set_id(1'b1, X_ADD, M_NO, W_WE, 3, 2, 5, 32'h80);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", ex_pc, 32'h40);
      check("stall_valid", ex_valid, 1'b1);
      check("stall_cnt", bubble_cnt, 16'd0);
    end
    stall = 1'b0;
    tick();
    check("post_stall_bubble", ex_valid, 1'b0);
    check("post_stall_pc_held", ex_pc, 32'h40);
    check("post_stall_cnt", bubble_cnt, 16'd1);

    // ---------------- halt, then reset during stall ----------------
    set_id(1'b1, X_LD, M_NO, W_NO, 0, 0, 0, 32'h50);
    id_hlt = 1'b1;
    tick();
    id_hlt = 1'b0;
    check("hlt_enters_ex", ex_pc, 32'h50);
    check("hlt_valid", ex_valid, 1'b1);
    check("halted_set", halted, 1'b1);
    set_id(1'b1, X_ADD, M_NO, W_WE, 3, 2, 5, 32'h54);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("halted_bubble", ex_valid, 1'b0);
      check("halted_sticky", halted, 1'b1);
    end
    rst = 1'b1; stall = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    check("rst_halted", halted, 1'b0);
    check("rst_pc", ex_pc, 32'h0);
    check("rst_cnt", bubble_cnt, 16'd0);
    set_id(1'b1, X_ADD, M_NO, W_WE, 0, 0, 5, 32'h58);
    #1;
    check("lus_after_rst", load_use_stall, 1'b0);
    tick();

    // ---------------- counter saturation on the CNT_W=2 instance ----------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, X_LD, M_LD, W_WE, 1, 0, 3, 32'h100 + 32'(i * 16));
      tick();
      set_id(1'b1, X_ADD, M_NO, W_WE, 3, 2, 5, 32'h104 + 32'(i * 16));
      tick();
      check("sat_cnt_w2", s_cnt, (i + 1 > 3) ? 3 : i + 1);
      check("sat_cnt_w16", bubble_cnt, i + 1);
      tick();
    end
    do_reset();
    check("sat_rst_w2", s_cnt, 2'd0);

    // ---------------- randomized traffic against the model ----------------
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(99) < 2);
      stall = ($urandom_range(99) < 20);
      flush = ($urandom_range(99) < 10);
      set_id($urandom_range(99) < 85, 15'($urandom), 2'($urandom), 3'($urandom),
             5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)), $urandom);
      id_hlt = ($urandom_range(99) < 2);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameter DATA_W, default 32: operand, immediate and PC width.
REQ-002 Parameter REG_AW, default 5: register address width.
REQ-003 Parameter CNT_W, default 16: bubble counter width.
REQ-004 Ports are listed one per line as name, direction, width, meaning; clock and reset come first.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  external hold request from downstream.
REQ-008 flush  in  1  kill the instruction currently in decode, e.g. on a taken branch or jump.
REQ-009 id_valid  in  1  decode holds a real instruction.
REQ-010 id_ex_ctrl / id_ma_ctrl / id_wb_ctrl  in  15 / 2 / 3  decode control words in the EXStage, MAStage and WBStage layouts of pipelinedefs.v.
REQ-011 id_hlt  in  1  decoded opcode is HLT.
REQ-012 id_pc, id_rs1_val, id_rs2_val, id_imm  in  DATA_W each  decode datapath values.
REQ-013 id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_AW each  register addresses.
REQ-014 ex_valid, ex_ex_ctrl, ex_ma_ctrl, ex_wb_ctrl, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  matching widths  registered EX-stage copies.
REQ-015 load_use_stall  out  1  combinational hold request to fetch/decode.
REQ-016 halted  out  1  sticky halt flag.
REQ-017 bubble_cnt  out  CNT_W  number of load-use bubbles inserted.

Function
REQ-018 Load-use detect: load_use_stall=1 iff all of the following hold: ex_valid; ex_ma_ctrl[MA_EN]=1; ex_ma_ctrl[MA_RW]=0; ex_wb_ctrl[WB_R_WE]=1; id_valid; and either (id_ex_ctrl[EX_NEED_RS1] with id_rs1_addr==ex_rd_addr) or (id_ex_ctrl[EX_NEED_RS2] with id_rs2_addr==ex_rd_addr).
REQ-019 load_use_stall is forced to 0 while flush=1 or halted=1.
REQ-020 Per-edge update priority: rst, then stall, then flush, then halted, then load_use_stall, then capture.
REQ-021 stall=1: every ex_* output, halted and bubble_cnt hold their values.
REQ-022 flush=1 with stall=0: insert a bubble.
REQ-023 halted=1 with stall=0: insert a bubble.
REQ-024 load_use_stall=1 with stall=0: insert a bubble; bubble_cnt increments, saturating at all-ones.
REQ-025 Bubble definition: ex_valid=0; ex_ex_ctrl, ex_ma_ctrl, ex_wb_ctrl all 0 (NOP encoding, no writes); datapath fields hold their previous values.
REQ-026 Capture: all id_* values are registered; ex_valid<=id_valid; when id_valid=0, the control words are zeroed.
REQ-027 Latency: exactly 1 cycle from decode to EX.
REQ-028 halted sets on the edge that captures id_valid=1 with id_hlt=1; the HLT instruction itself enters EX.
REQ-029 halted clears only on rst.
REQ-030 A bubble inserted for load-use lasts one cycle; the ex_valid=0 it produces clears the hazard the next cycle.
REQ-031 bubble_cnt does not count flush or halt bubbles.

Reset
REQ-032 On rst=1 at a clock edge: ex_valid=0, all ex_* controls and datapath fields = 0, halted=0, bubble_cnt=0.
REQ-033 Reset asserted mid-stall, mid-bubble or mid-halt overrides everything, including stall=1.
REQ-034 load_use_stall reads 0 on the cycle after reset, because ex_valid=0.

Verification
REQ-035 Load then dependent ADD: EX holds a load with rd=3; ID holds an ADD with rs1=3 and NEED_RS1 set -> load_use_stall=1 for one cycle, then ex_valid=0 with zero controls, bubble_cnt 0->1; the next cycle captures the ADD.
REQ-036 Store after a load: a store with NEED_RS1=0 and NEED_RS2=1, rs2=3 -> stall fires; the same store with rs2=4 -> no stall.
REQ-037 stall=1 for 3 cycles while capturing PC=0x40 -> ex_pc stays 0x40 and ex_valid stays 1; no bubble; bubble_cnt is unchanged.
REQ-038 flush=1 coincident with a load-use hazard -> load_use_stall=0, a bubble is inserted, bubble_cnt is unchanged.
REQ-039 HLT captured -> halted=1 next cycle; later id_valid=1 instructions produce ex_valid=0; rst clears halted to 0.
REQ-040 bubble_cnt preset near saturation via repeated hazards with CNT_W=2 -> the count reaches 3 and holds at 3; rst returns it to 0.
